// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O bridge: LED mode encodings and
// STATUS-mode bit positions.
package board_io_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_STATUS = 2'd1;
    localparam logic [1:0] MODE_DEBUG  = 2'd2;
    localparam logic [1:0] MODE_WALK   = 2'd3;

    // Bit positions inside the STATUS LED word; core LEDs fill upward from ST_LED.
    localparam int ST_HB  = 0;
    localparam int ST_RX  = 1;
    localparam int ST_TX  = 2;
    localparam int ST_RES = 3;
    localparam int ST_LED = 4;

endpackage

// File: rtl/io_stretch.sv
// Activity stretcher: a falling edge on sig reloads a down-counter with
// all-ones; active stays high while the counter is nonzero.
module io_stretch
    import board_io_pkg::*;
#(
    parameter int STRETCH_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic active
);

    logic                 prev;
    logic [STRETCH_W-1:0] cnt;
    logic                 fall;

    assign fall = prev & ~sig;

    // Edge history plus reload/decrement counter; a trigger beats the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= sig;
            if (fall) begin
                cnt <= '1;
            end else if (cnt != '0) begin
                cnt <= cnt - STRETCH_W'(1);
            end
        end
    end

    assign active = (cnt != '0);

endmodule

// File: rtl/board_io_bridge.sv
// Board-side adapter between FPGA pins and the core: reset sequencing,
// UART pin conditioning, activity stretchers, heartbeat and LED mode mux.
module board_io_bridge
    import board_io_pkg::*;
#(
    parameter int LEDS        = 8,
    parameter int CORE_LEDS   = 4,
    parameter int DEBUG_W     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_W   = 20,
    parameter int HB_W        = 24,
    parameter int POR_CYCLES  = 16
) (
    input  logic                 XCLK,
    input  logic                 XRES,
    input  logic                 RX_PIN,
    output logic                 TX_PIN,
    output logic [LEDS-1:0]      LED_PIN,
    input  logic [1:0]           MODE,
    output logic                 CORE_RXD,
    input  logic                 CORE_TXD,
    input  logic [CORE_LEDS-1:0] CORE_LED,
    input  logic [DEBUG_W-1:0]   CORE_DEBUG,
    output logic                 CORE_RES
);

    localparam int POR_W = $clog2(POR_CYCLES + 1);
    // Scratch width large enough to hold any LED source before truncation.
    localparam int WIDE  = LEDS + CORE_LEDS + DEBUG_W + 4;

    logic [1:0]             rst_sync;
    logic [POR_W-1:0]       por_cnt;
    logic                   core_res;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   tx_q;
    logic [1:0]             mode_s1;
    logic [1:0]             mode_s2;
    logic [HB_W-1:0]        hb_cnt;
    logic [LEDS-1:0]        walk;
    logic [LEDS-1:0]        led_q;
    logic [LEDS-1:0]        led_next;
    logic                   rx_act;
    logic                   tx_act;
    logic                   heartbeat;
    logic [WIDE-1:0]        direct_w;
    logic [WIDE-1:0]        status_w;
    logic [WIDE-1:0]        debug_w;
    logic                   unused_wide;

    // Release synchroniser then POR down-counter; core reset drops once and stays low.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            rst_sync <= 2'b00;
            por_cnt  <= POR_W'(POR_CYCLES);
            core_res <= 1'b1;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            if (rst_sync[1]) begin
                if (por_cnt != '0) begin
                    por_cnt <= por_cnt - POR_W'(1);
                end
                if (por_cnt <= POR_W'(1)) begin
                    core_res <= 1'b0;
                end
            end
        end
    end

    // RX synchroniser chain, TX output register and MODE synchroniser.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            rx_sync <= '1;
            tx_q    <= 1'b1;
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], RX_PIN};
            tx_q    <= CORE_TXD;
            mode_s1 <= MODE;
            mode_s2 <= mode_s1;
        end
    end

    // Free-running heartbeat; the walking LED steps left on every counter wrap.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            hb_cnt <= '0;
            walk   <= LEDS'(1);
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
            if (hb_cnt == '1) begin
                walk <= (walk << 1) | (walk >> (LEDS - 1));
            end
        end
    end

    assign heartbeat = hb_cnt[HB_W-1];

    io_stretch #(.STRETCH_W(STRETCH_W)) u_rx_stretch (
        .clk    (XCLK),
        .rst_n  (XRES),
        .sig    (rx_sync[SYNC_STAGES-1]),
        .active (rx_act)
    );

    io_stretch #(.STRETCH_W(STRETCH_W)) u_tx_stretch (
        .clk    (XCLK),
        .rst_n  (XRES),
        .sig    (tx_q),
        .active (tx_act)
    );

    // Build each LED source zero-extended, then select and truncate to LEDS.
    always_comb begin
        direct_w = '0;
        direct_w[DEBUG_W+CORE_LEDS-1:0] = {CORE_DEBUG, CORE_LED};
        status_w = '0;
        status_w[ST_HB]  = heartbeat;
        status_w[ST_RX]  = rx_act;
        status_w[ST_TX]  = tx_act;
        status_w[ST_RES] = core_res;
        status_w[ST_LED +: CORE_LEDS] = CORE_LED;
        debug_w = '0;
        debug_w[DEBUG_W-1:0] = CORE_DEBUG;
        case (mode_s2)
            MODE_DIRECT: led_next = direct_w[LEDS-1:0];
            MODE_STATUS: led_next = status_w[LEDS-1:0];
            MODE_DEBUG:  led_next = debug_w[LEDS-1:0];
            MODE_WALK:   led_next = walk;
            default:     led_next = '0;
        endcase
    end

    // Bits above LEDS are intentionally dropped by the truncation.
    assign unused_wide = ^{direct_w[WIDE-1:LEDS], status_w[WIDE-1:LEDS], debug_w[WIDE-1:LEDS]};

    // Registered LED output.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            led_q <= '0;
        end else begin
            led_q <= led_next;
        end
    end

    assign TX_PIN   = tx_q;
    assign CORE_RXD = rx_sync[SYNC_STAGES-1];
    assign CORE_RES = core_res;
    assign LED_PIN  = led_q;

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed bench for board_io_bridge (LEDS=8, STRETCH_W=4, HB_W=4, POR_CYCLES=4)
// with a second LEDS=2 instance for truncation.
module tb_board_io_bridge;

    logic       XCLK = 1'b0;
    logic       XRES = 1'b0;
    logic       RX_PIN = 1'b1;
    logic       CORE_TXD = 1'b1;
    logic [1:0] MODE = 2'd0;
    logic [3:0] CORE_LED = 4'h0;
    logic [3:0] CORE_DEBUG = 4'h0;

    wire        TX_PIN;
    wire        CORE_RXD;
    wire        CORE_RES;
    wire [7:0]  LED_PIN;
    wire        tx2;
    wire        rxd2;
    wire        res2;
    wire [1:0]  led2;

    int checks = 0;
    int errors = 0;
    int rel_cnt = 0;
    logic [7:0] exp8;
    logic       exp1;

    board_io_bridge #(
        .LEDS(8), .CORE_LEDS(4), .DEBUG_W(4), .SYNC_STAGES(2),
        .STRETCH_W(4), .HB_W(4), .POR_CYCLES(4)
    ) dut (
        .XCLK(XCLK), .XRES(XRES), .RX_PIN(RX_PIN), .TX_PIN(TX_PIN),
        .LED_PIN(LED_PIN), .MODE(MODE), .CORE_RXD(CORE_RXD),
        .CORE_TXD(CORE_TXD), .CORE_LED(CORE_LED), .CORE_DEBUG(CORE_DEBUG),
        .CORE_RES(CORE_RES)
    );

    board_io_bridge #(
        .LEDS(2), .CORE_LEDS(4), .DEBUG_W(4), .SYNC_STAGES(2),
        .STRETCH_W(4), .HB_W(4), .POR_CYCLES(4)
    ) dut2 (
        .XCLK(XCLK), .XRES(XRES), .RX_PIN(RX_PIN), .TX_PIN(tx2),
        .LED_PIN(led2), .MODE(MODE), .CORE_RXD(rxd2),
        .CORE_TXD(CORE_TXD), .CORE_LED(CORE_LED), .CORE_DEBUG(CORE_DEBUG),
        .CORE_RES(res2)
    );

    // Clock and reset-relative edge counter (edge k after release => rel_cnt == k).
    always #5 XCLK = ~XCLK;

    always @(posedge XCLK or negedge XRES) begin
        if (!XRES) rel_cnt <= 0;
        else       rel_cnt <= rel_cnt + 1;
    end

    task automatic tick();
        @(posedge XCLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (LED_PIN !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", LED_PIN); end
        checks++; if (TX_PIN !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX_PIN); end
        checks++; if (CORE_RXD !== 1'b1) begin errors++; $display("FAIL reset_rxd: got %b expected 1", CORE_RXD); end
        checks++; if (CORE_RES !== 1'b1) begin errors++; $display("FAIL reset_res: got %b expected 1", CORE_RES); end
        checks++; if (led2 !== 2'b00) begin errors++; $display("FAIL reset_led2: got %b expected 00", led2); end
        XRES = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp1 = (e < 6);
            checks++; if (CORE_RES !== exp1) begin errors++; $display("FAIL por_release edge %0d: got %b expected %b", e, CORE_RES, exp1); end
            checks++; if (res2 !== exp1) begin errors++; $display("FAIL por_release2 edge %0d: got %b expected %b", e, res2, exp1); end
        end
        repeat (13) tick();
        XRES = 1'b0;
        #1;
        checks++; if (CORE_RES !== 1'b1) begin errors++; $display("FAIL por_async: got %b expected 1", CORE_RES); end
        checks++; if (LED_PIN !== 8'h00) begin errors++; $display("FAIL pulse_led: got %h expected 00", LED_PIN); end
        tick();
        tick();
        XRES = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp1 = (e < 6);
            checks++; if (CORE_RES !== exp1) begin errors++; $display("FAIL por_rerelease edge %0d: got %b expected %b", e, CORE_RES, exp1); end
        end
    endtask

    task automatic test_direct();
        CORE_DEBUG = 4'hA;
        CORE_LED   = 4'h5;
        checks++; if (LED_PIN !== 8'h00) begin errors++; $display("FAIL direct_before: got %h expected 00", LED_PIN); end
        tick();
        checks++; if (LED_PIN !== 8'hA5) begin errors++; $display("FAIL direct: got %h expected a5", LED_PIN); end
        checks++; if (led2 !== 2'b01) begin errors++; $display("FAIL direct_trunc: got %b expected 01", led2); end
    endtask

    task automatic test_rx_stretch();
        MODE = 2'd1;
        repeat (4) tick();
        RX_PIN = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 1) begin
                checks++; if (CORE_RXD !== 1'b1) begin errors++; $display("FAIL rxd_lat1: got %b expected 1", CORE_RXD); end
            end
            if (e == 2) begin
                checks++; if (CORE_RXD !== 1'b0) begin errors++; $display("FAIL rxd_lat2: got %b expected 0", CORE_RXD); end
            end
            exp1 = (e >= 4 && e <= 18);
            checks++; if (LED_PIN[1] !== exp1) begin errors++; $display("FAIL rx_stretch edge %0d: got %b expected %b", e, LED_PIN[1], exp1); end
            if (e == 5) RX_PIN = 1'b1;
        end
        RX_PIN = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp1 = (e >= 4 && e <= 26);
            checks++; if (LED_PIN[1] !== exp1) begin errors++; $display("FAIL rx_retrigger edge %0d: got %b expected %b", e, LED_PIN[1], exp1); end
            if (e == 3) RX_PIN = 1'b1;
            if (e == 8) RX_PIN = 1'b0;
        end
        RX_PIN = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_both_and_heartbeat();
        RX_PIN = 1'b0;
        tick();
        checks++; if (TX_PIN !== 1'b1) begin errors++; $display("FAIL tx_before: got %b expected 1", TX_PIN); end
        CORE_TXD = 1'b0;
        tick();
        checks++; if (TX_PIN !== 1'b0) begin errors++; $display("FAIL tx_lat: got %b expected 0", TX_PIN); end
        checks++; if (CORE_RXD !== 1'b0) begin errors++; $display("FAIL rxd_both: got %b expected 0", CORE_RXD); end
        tick();
        checks++; if (LED_PIN[2:1] !== 2'b00) begin errors++; $display("FAIL both_early: got %b expected 00", LED_PIN[2:1]); end
        tick();
        checks++; if (LED_PIN[2:1] !== 2'b11) begin errors++; $display("FAIL both_act: got %b expected 11", LED_PIN[2:1]); end
        checks++; if (LED_PIN[3] !== 1'b0) begin errors++; $display("FAIL status_res: got %b expected 0", LED_PIN[3]); end
        RX_PIN   = 1'b1;
        CORE_TXD = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp1 = (((rel_cnt - 1) % 16) >= 8);
            checks++; if (LED_PIN[0] !== exp1) begin errors++; $display("FAIL heartbeat cnt %0d: got %b expected %b", rel_cnt, LED_PIN[0], exp1); end
        end
    endtask

    task automatic test_walk();
        MODE = 2'd0;
        repeat (4) tick();
        checks++; if (LED_PIN !== 8'hA5) begin errors++; $display("FAIL walk_pre: got %h expected a5", LED_PIN); end
        MODE = 2'd3;
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++; if (LED_PIN !== 8'hA5) begin errors++; $display("FAIL mode_lat edge %0d: got %h expected a5", e, LED_PIN); end
        end
        for (int e = 3; e <= 140; e++) begin
            tick();
            exp8 = 8'h01 << (((rel_cnt - 1) / 16) % 8);
            checks++; if (LED_PIN !== exp8) begin errors++; $display("FAIL walk edge %0d: got %h expected %h", e, LED_PIN, exp8); end
        end
    endtask

    task automatic test_debug();
        MODE = 2'd2;
        CORE_DEBUG = 4'hF;
        repeat (4) tick();
        checks++; if (LED_PIN !== 8'h0F) begin errors++; $display("FAIL debug: got %h expected 0f", LED_PIN); end
        checks++; if (led2 !== 2'b11) begin errors++; $display("FAIL debug_trunc: got %b expected 11", led2); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_rx_stretch();
        test_both_and_heartbeat();
        test_walk();
        test_debug();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
